// File: rtl/photon_avg_accumulator_pkg.sv
// Shared types and default widths for the Raman photon averaging chain.
package raman_avg_pkg;

    localparam int AVG_N  = 20;
    localparam int AVG_SW = 4;

    localparam logic [AVG_N-1:0] AVG_MAX = {AVG_N{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCUM     = 2'd1,
        DIV_START = 2'd2,
        DIV_WAIT  = 2'd3
    } avg_state_t;

endpackage

// File: rtl/photon_avg_accumulator_if.sv
// Start/result handshake between the photon averager and the sequential divider.
interface photon_avg_accumulator_if
    import raman_avg_pkg::*;
#(
    parameter int N = AVG_N
);
    logic         div_start;
    logic [N-1:0] div_divident;
    logic [N-1:0] div_divider;
    logic         div_ready;
    logic [N-1:0] div_quotient;
    logic [N-1:0] div_reminder;

    modport master (
        output div_start,
        output div_divident,
        output div_divider,
        input  div_ready,
        input  div_quotient,
        input  div_reminder
    );

    modport slave (
        input  div_start,
        input  div_divident,
        input  div_divider,
        output div_ready,
        output div_quotient,
        output div_reminder
    );
endinterface

// File: rtl/photon_avg_accumulator_sat_add.sv
// N-bit unsigned adder that clamps to all-ones and flags when it does.
module avg_sat_add
    import raman_avg_pkg::*;
#(
    parameter int N = AVG_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         sat
);
    logic [N:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign sat      = full_sum[N];
    assign y        = full_sum[N] ? {N{1'b1}} : full_sum[N-1:0];
endmodule

// File: rtl/photon_avg_accumulator.sv
// Accumulates n_avg photon-count samples, then divides the sum by n_avg via the external divider.
// Define PHOTON_AVG_ROUND_EN to bias the dividend by n_avg/2 for a round-to-nearest average.
module photon_avg_accumulator
    import raman_avg_pkg::*;
#(
    parameter int N  = AVG_N,
    parameter int SW = AVG_SW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go,
    input  logic [N-1:0]              n_avg,
    input  logic                      sample_valid,
    input  logic [SW-1:0]             sample,
    photon_avg_accumulator_if.master  div,
    output logic [N-1:0]              avg_out,
    output logic [N-1:0]              avg_rem,
    output logic                      avg_valid,
    output logic                      busy,
    output logic                      overflow
);
    avg_state_t   state_reg, state_next;
    logic [N-1:0] n_avg_reg, n_avg_next;
    logic [N-1:0] sum_reg, sum_next;
    logic [N-1:0] count_reg, count_next;
    logic         overflow_reg, overflow_next;
    logic         div_start_reg, div_start_next;
    logic [N-1:0] divident_reg, divident_next;
    logic [N-1:0] divider_reg, divider_next;
    logic [N-1:0] avg_out_reg, avg_out_next;
    logic [N-1:0] avg_rem_reg, avg_rem_next;
    logic         avg_valid_reg, avg_valid_next;

    logic [N-1:0] sample_ext;
    logic [N-1:0] acc_sum;
    logic         acc_sat;
    logic [N-1:0] count_inc;
    logic [N-1:0] final_dividend;
    logic         final_sat;

    assign sample_ext = {{(N-SW){1'b0}}, sample};
    assign count_inc  = count_reg + N'(1);

    avg_sat_add #(.N(N)) u_acc_add (
        .a   (sum_reg),
        .b   (sample_ext),
        .y   (acc_sum),
        .sat (acc_sat)
    );

`ifdef PHOTON_AVG_ROUND_EN
    logic [N-1:0] bias_sum;
    logic         bias_sat;

    // Bias is applied to the post-final-sample sum so the divider still starts one cycle later.
    avg_sat_add #(.N(N)) u_bias_add (
        .a   (acc_sum),
        .b   (n_avg_reg >> 1),
        .y   (bias_sum),
        .sat (bias_sat)
    );

    assign final_dividend = bias_sum;
    assign final_sat      = acc_sat | bias_sat;
`else
    assign final_dividend = acc_sum;
    assign final_sat      = acc_sat;
`endif

    always_comb begin
        state_next     = state_reg;
        n_avg_next     = n_avg_reg;
        sum_next       = sum_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        div_start_next = 1'b0;
        divident_next  = divident_reg;
        divider_next   = divider_reg;
        avg_out_next   = avg_out_reg;
        avg_rem_next   = avg_rem_reg;
        avg_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // A zero-length run is refused so the divider never sees a zero divisor.
                if (go && (n_avg != '0)) begin
                    n_avg_next    = n_avg;
                    sum_next      = '0;
                    count_next    = '0;
                    overflow_next = 1'b0;
                    state_next    = ACCUM;
                end
            end
            ACCUM: begin
                if (sample_valid) begin
                    sum_next      = acc_sum;
                    count_next    = count_inc;
                    overflow_next = overflow_reg | acc_sat;
                    if (count_inc == n_avg_reg) begin
                        overflow_next  = overflow_reg | final_sat;
                        divident_next  = final_dividend;
                        divider_next   = n_avg_reg;
                        div_start_next = 1'b1;
                        state_next     = DIV_START;
                    end
                end
            end
            DIV_START: begin
                state_next = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (div.div_ready) begin
                    avg_out_next   = div.div_quotient;
                    avg_rem_next   = div.div_reminder;
                    avg_valid_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            n_avg_reg     <= '0;
            sum_reg       <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            div_start_reg <= 1'b0;
            divident_reg  <= '0;
            divider_reg   <= '0;
            avg_out_reg   <= '0;
            avg_rem_reg   <= '0;
            avg_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            n_avg_reg     <= n_avg_next;
            sum_reg       <= sum_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            div_start_reg <= div_start_next;
            divident_reg  <= divident_next;
            divider_reg   <= divider_next;
            avg_out_reg   <= avg_out_next;
            avg_rem_reg   <= avg_rem_next;
            avg_valid_reg <= avg_valid_next;
        end
    end

    assign div.div_start    = div_start_reg;
    assign div.div_divident = divident_reg;
    assign div.div_divider  = divider_reg;

    assign avg_out   = avg_out_reg;
    assign avg_rem   = avg_rem_reg;
    assign avg_valid = avg_valid_reg;
    assign busy      = (state_reg != IDLE);
    assign overflow  = overflow_reg;
endmodule

// File: tb/tb_photon_avg_accumulator.sv
// Randomized bench for photon_avg_accumulator with a behavioural divider and averaging model.
// Expectations follow PHOTON_AVG_ROUND_EN when the bench is built with it.
module tb_photon_avg_accumulator;
    import raman_avg_pkg::*;

    localparam int     N    = AVG_N;
    localparam int     SW   = AVG_SW;
    localparam int     LAT  = N + 2;
    localparam int     BIG  = 32'h7fff_ffff;
    localparam longint MAXL = (longint'(1) << N) - 1;

    typedef struct {
        int           start_cyc;
        logic [N-1:0] dvd;
        logic [N-1:0] dvs;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic [N-1:0]  n_avg = '0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample = '0;
    logic [N-1:0]  avg_out, avg_rem;
    logic          avg_valid, busy, overflow;

    always #5 clk = ~clk;

    photon_avg_accumulator_if #(.N(N)) div_bus ();

    photon_avg_accumulator #(.N(N), .SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .n_avg        (n_avg),
        .sample_valid (sample_valid),
        .sample       (sample),
        .div          (div_bus),
        .avg_out      (avg_out),
        .avg_rem      (avg_rem),
        .avg_valid    (avg_valid),
        .busy         (busy),
        .overflow     (overflow)
    );

    // Sequential divider model: ready drops when start is sampled, result appears N edges later.
    logic         ready_m = 1'b1;
    logic [N-1:0] q_m = '0, r_m = '0, a_m = '0, b_m = '0;
    int           cnt_m = 0;

    assign div_bus.div_ready    = ready_m;
    assign div_bus.div_quotient = q_m;
    assign div_bus.div_reminder = r_m;

    always @(posedge clk) begin
        if (div_bus.div_start) begin
            cnt_m   <= N;
            ready_m <= 1'b0;
            a_m     <= div_bus.div_divident;
            b_m     <= div_bus.div_divider;
        end else if (cnt_m != 0) begin
            cnt_m <= cnt_m - 1;
            if (cnt_m == 1) begin
                ready_m <= 1'b1;
                q_m     <= (b_m == '0) ? {N{1'b1}} : a_m / b_m;
                r_m     <= (b_m == '0) ? a_m : a_m % b_m;
            end
        end
    end

    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    int           runs = 0;
    bit           chk_en = 1'b0;
    int           busy_from = BIG;
    int           busy_to = BIG;
    logic [N-1:0] hold_q = '0;
    logic [N-1:0] hold_r = '0;
    exp_t         q_exp[$];
    int           smp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit   exp_start;
            bit   exp_valid;
            exp_t e;
            exp_start = (q_exp.size() > 0) && (q_exp[0].start_cyc == cyc);
            exp_valid = (q_exp.size() > 0) && (q_exp[0].start_cyc + LAT == cyc);
            chk("busy", longint'(busy), longint'(cyc >= busy_from && cyc <= busy_to));
            chk("div_start", longint'(div_bus.div_start), longint'(exp_start));
            chk("avg_valid", longint'(avg_valid), longint'(exp_valid));
            if (exp_start) begin
                chk("div_divident", longint'(div_bus.div_divident), longint'(q_exp[0].dvd));
                chk("div_divider", longint'(div_bus.div_divider), longint'(q_exp[0].dvs));
            end
            if (exp_valid) begin
                e = q_exp.pop_front();
                hold_q = e.q;
                hold_r = e.r;
                runs++;
                chk("overflow", longint'(overflow), longint'(e.ovf));
                $display("run %0d: n=%0d dividend=%0d avg=%0d rem=%0d ovf=%0d",
                         runs, e.dvs, e.dvd, e.q, e.r, e.ovf);
            end
            chk("avg_out", longint'(avg_out), longint'(hold_q));
            chk("avg_rem", longint'(avg_rem), longint'(hold_r));
            if (rst) begin
                hold_q = '0;
                hold_r = '0;
                q_exp.delete();
            end
        end
    end

    // Runs one averaging job over smp[]; returns when the result strobe cycle is current.
    task automatic run_avg(input int n, input int gap_min, input int gap_max, input bit junk,
                           output logic [N-1:0] e_q, output logic [N-1:0] e_r);
        longint raw;
        longint s;
        longint b;
        int     gaps;
        int     k;
        exp_t   e;
        raw = 0;
        go = 1'b1;
        n_avg = N'(n);
        @(posedge clk); #1;
        go = 1'b0;
        busy_from = cyc;
        busy_to = BIG;
        for (int i = 0; i < n; i++) begin
            gaps = $urandom_range(gap_min, gap_max);
            repeat (gaps) begin
                sample_valid = 1'b0;
                sample = SW'($urandom);
                if (junk) begin
                    go = ($urandom_range(0, 3) == 0);
                    n_avg = N'($urandom_range(0, 50));
                end
                @(posedge clk); #1;
            end
            go = 1'b0;
            sample_valid = 1'b1;
            sample = SW'(smp[i]);
            raw += smp[i];
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        k = cyc;
        s = (raw > MAXL) ? MAXL : raw;
        e.ovf = (raw > MAXL);
`ifdef PHOTON_AVG_ROUND_EN
        b = s + (n >> 1);
        if (b > MAXL) begin
            b = MAXL;
            e.ovf = 1'b1;
        end
`else
        b = s;
`endif
        e.start_cyc = k;
        e.dvd = N'(b);
        e.dvs = N'(n);
        e.q = N'(b / n);
        e.r = N'(b % n);
        q_exp.push_back(e);
        busy_to = k + LAT - 1;
        while (cyc < k + LAT) begin
            sample_valid = $urandom_range(0, 1);
            sample = SW'($urandom);
            go = (junk && (cyc < k + LAT - 2) && ($urandom_range(0, 3) == 0));
            n_avg = N'($urandom_range(0, 50));
            @(posedge clk); #1;
        end
        go = 1'b0;
        sample_valid = 1'b0;
        e_q = e.q;
        e_r = e.r;
    endtask

    task automatic idle_junk(input int c);
        repeat (c) begin
            sample_valid = $urandom_range(0, 1);
            sample = SW'($urandom);
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        logic [N-1:0] eq, er;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        busy_from = BIG;
        chk_en = 1'b1;
        chk("rst_avg_out", longint'(avg_out), 0);
        chk("rst_avg_rem", longint'(avg_rem), 0);
        chk("rst_avg_valid", longint'(avg_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_overflow", longint'(overflow), 0);
        chk("rst_div_start", longint'(div_bus.div_start), 0);

        // Four back-to-back samples.
        smp = '{3, 5, 7, 9};
        run_avg(4, 0, 0, 1'b0, eq, er);
        chk("t1_avg_valid", longint'(avg_valid), 1);
        chk("t1_avg_out", longint'(avg_out), 6);
        chk("t1_overflow", longint'(overflow), 0);
        chk("t1_divider", longint'(div_bus.div_divider), 4);
`ifdef PHOTON_AVG_ROUND_EN
        chk("t1_divident", longint'(div_bus.div_divident), 26);
        chk("t1_avg_rem", longint'(avg_rem), 2);
`else
        chk("t1_divident", longint'(div_bus.div_divident), 24);
        chk("t1_avg_rem", longint'(avg_rem), 0);
`endif
        idle_junk(3);

        // Samples separated by two-cycle gaps.
        smp = '{2, 2, 1};
        run_avg(3, 2, 2, 1'b0, eq, er);
`ifdef PHOTON_AVG_ROUND_EN
        chk("t2_divident", longint'(div_bus.div_divident), 6);
        chk("t2_avg_out", longint'(avg_out), 2);
        chk("t2_avg_rem", longint'(avg_rem), 0);
`else
        chk("t2_divident", longint'(div_bus.div_divident), 5);
        chk("t2_avg_out", longint'(avg_out), 1);
        chk("t2_avg_rem", longint'(avg_rem), 2);
`endif
        idle_junk(2);

        // go with n_avg of zero is refused.
        go = 1'b1;
        n_avg = '0;
        @(posedge clk); #1;
        go = 1'b0;
        chk("zero_go_busy", longint'(busy), 0);
        idle_junk(3);
        chk("zero_go_busy_later", longint'(busy), 0);

        // Stray go pulses while busy must not disturb the run.
        smp = '{8, 4, 6};
        run_avg(3, 1, 2, 1'b1, eq, er);
        chk("t4_avg_out", longint'(avg_out), 6);

        // Abort after two of four samples, then a clean run.
        go = 1'b1;
        n_avg = N'(4);
        @(posedge clk); #1;
        go = 1'b0;
        busy_from = cyc;
        busy_to = BIG;
        sample_valid = 1'b1;
        sample = SW'(3);
        repeat (2) begin
            @(posedge clk); #1;
        end
        sample_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        busy_from = BIG;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_avg_out", longint'(avg_out), 0);
        smp = '{8, 4};
        run_avg(2, 0, 0, 1'b0, eq, er);
        chk("t5_avg_out", longint'(avg_out), 6);

        // Random runs, some starting in the same cycle as the previous strobe.
        for (int r = 0; r < 30; r++) begin
            int n;
            n = $urandom_range(1, 12);
            smp.delete();
            for (int i = 0; i < n; i++) smp.push_back($urandom_range(0, 15));
            run_avg(n, 0, 2, 1'b1, eq, er);
            idle_junk($urandom_range(0, 2));
        end

        // Saturating run: 70000 * 15 exceeds 2^20-1.
        smp.delete();
        for (int i = 0; i < 70000; i++) smp.push_back(15);
        run_avg(70000, 0, 0, 1'b0, eq, er);
        chk("sat_avg_out", longint'(avg_out), 14);
        chk("sat_avg_rem", longint'(avg_rem), 68575);
        chk("sat_overflow", longint'(overflow), 1);
        chk("sat_divident", longint'(div_bus.div_divident), MAXL);

        idle_junk(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/photon_avg_accumulator.md
Name: photon_avg_accumulator

Overview:
- Upstream stage of the 20-bit sequential divider in the Raman averaging chain.
- Sums a programmable number (n_avg, nominally 100000) of per-gate photon-count samples into an N-bit saturating accumulator.
- When the run completes, drives the divider's start/divident/divider, waits for its ready, and presents the averaged result with a one-cycle valid strobe.

Parameters:
- N, 20, datapath width; must equal the divider's N.
- SW, 4, sample width in bits (photon counts per gate).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- go  in  1  start a new averaging run (single-cycle pulse)
- n_avg  in  N  number of samples to average; latched on accepted go
- sample_valid  in  1  sample qualifier
- sample  in  SW  photon count, unsigned
- div_start  out  1  to divider start
- div_divident  out  N  to divider divident
- div_divider  out  N  to divider divider
- div_ready  in  1  from divider ready
- div_quotient  in  N  from divider quotient
- div_reminder  in  N  from divider reminder
- avg_out  out  N  averaged value (quotient)
- avg_rem  out  N  remainder
- avg_valid  out  1  one-cycle strobe; avg_out/avg_rem valid while high and held until the next capture
- busy  out  1  high in every state except IDLE
- overflow  out  1  sticky saturation flag for the current or last run

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; all registers and outputs 0 (div_start, avg_out, avg_rem, avg_valid, busy, overflow, sum, count). rst has priority over every other input.
- State IDLE:
  - go=1 and n_avg!=0: latch n_avg; clear sum, count and overflow; go to ACCUM.
  - go=1 and n_avg==0: ignored, stay IDLE. No division by zero is ever issued.
- State ACCUM:
  - Each sample_valid=1 cycle: sum <= sat(sum + zero-extended sample) and count <= count+1.
  - sat() clamps to 2^N-1 and sets overflow=1. overflow stays set until the next accepted go.
  - Gaps in sample_valid are allowed; the state holds.
  - The edge that accepts sample number n_avg moves to DIV_START.
- State DIV_START:
  - div_start=1 for exactly this one cycle.
  - div_divident=sum, div_divider=latched n_avg; both are registered and held stable until the next run.
  - Next state: DIV_WAIT.
- State DIV_WAIT:
  - The divider's ready drops on the edge that samples start, so no blanking cycle is needed.
  - On div_ready=1: capture avg_out=div_quotient and avg_rem=div_reminder; assert avg_valid for one cycle; go to IDLE.
- Latency: avg_valid is high N+2 cycles after the edge that accepted the final sample (22 for N=20).
- Ignored inputs:
  - go while busy=1.
  - sample_valid in IDLE, DIV_START and DIV_WAIT; those samples are dropped, not counted.
- Reset mid-run: returns to IDLE immediately and no result is produced. The divider has no reset and may finish a stale division; its ready/quotient are ignored outside DIV_WAIT. The next div_start restarts the divider unconditionally.
- go in the same cycle as avg_valid: accepted (state is IDLE).

Optional Feature:
- Macro: PHOTON_AVG_ROUND_EN.
- Defined: div_divident = sat(sum + (n_avg>>1)), giving a round-to-nearest quotient. This addition also sets overflow if it saturates. avg_rem is then the remainder of the biased dividend.
- Undefined: div_divident = sum (truncating average).
- Latency is unchanged in both builds; the bias is added combinationally when entering DIV_START.

Decomposition:
- Package raman_avg_pkg:
  - State enum {IDLE, ACCUM, DIV_START, DIV_WAIT}.
  - Default widths AVG_N=20 and AVG_SW=4.
  - Constant AVG_MAX = 2^AVG_N-1.
- One natural sub-module, avg_sat_add: an N-bit unsigned saturating adder (a, b -> y, sat). It is used for sample accumulation and for the rounding bias.

Test Plan (divider model instantiated with N=20):
- go, n_avg=4; samples 3,5,7,9 back-to-back -> div_start one cycle with divident=24, divider=4; avg_out=6, avg_rem=0; avg_valid 22 cycles after the 4th sample; overflow=0.
- go, n_avg=3; samples 2,2,1 with 2-cycle gaps -> divident=5, avg_out=1, avg_rem=2. With PHOTON_AVG_ROUND_EN: divident=6, avg_out=2, avg_rem=0.
- go, n_avg=100000; sample=15 every cycle -> sum saturates at 1048575, overflow=1, avg_out=10, avg_rem=48575.
- go with n_avg=0 -> busy stays 0, no div_start. A second go while busy -> ignored, and the result matches the first run.
- rst asserted after 2 of 4 samples, then new run n_avg=2 with samples 8,4 -> exactly one avg_valid, avg_out=6; no strobe from the aborted run.
